// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: per-channel synchroniser, saturating stability counter,
// registered debounced level and one-cycle rise/fall pulses.
module debouncer_multi #(
   parameter int   CHANNELS      = 2,
   parameter int   STABLE_CYCLES = 1000,
   parameter int   SYNC_STAGES   = 2,
   parameter logic RESET_LEVEL   = 1'b1
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                tickEn,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                anyChange
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_r;
   logic [CHANNELS-1:0][CNT_W-1:0]       cnt_r;
   logic [CHANNELS-1:0][CNT_W-1:0]       cnt_s;
   logic [CHANNELS-1:0]                  level_s;
   logic [CHANNELS-1:0]                  out_r;
   logic [CHANNELS-1:0]                  out_s;
   logic [CHANNELS-1:0]                  load_s;
   logic [CHANNELS-1:0]                  rise_r;
   logic [CHANNELS-1:0]                  fall_r;
   logic                                 any_r;

   // Per-channel counter and level update; the >= guard keeps the counter from wrapping.
   always_comb begin
      cnt_s   = cnt_r;
      out_s   = out_r;
      load_s  = '0;
      level_s = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         level_s[i] = sync_r[i][SYNC_STAGES-1];
         if (level_s[i] == out_r[i]) begin
            cnt_s[i] = '0;
         end else if (!tickEn) begin
            cnt_s[i] = cnt_r[i];
         end else if (cnt_r[i] >= CNT_MAX) begin
            load_s[i] = 1'b1;
            out_s[i]  = level_s[i];
            cnt_s[i]  = '0;
         end else begin
            cnt_s[i] = cnt_r[i] + CNT_ONE;
         end
      end
   end

   // State registers: synchroniser chains, counters, debounced levels and edge pulses.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync_r <= {CHANNELS{{SYNC_STAGES{RESET_LEVEL}}}};
         cnt_r  <= '0;
         out_r  <= {CHANNELS{RESET_LEVEL}};
         rise_r <= '0;
         fall_r <= '0;
         any_r  <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], in[i]};
         end
         cnt_r  <= cnt_s;
         out_r  <= out_s;
         rise_r <= load_s & out_s;
         fall_r <= load_s & ~out_s;
         any_r  <= |load_s;
      end
   end

   assign out       = out_r;
   assign rise      = rise_r;
   assign fall      = fall_r;
   assign anyChange = any_r;

endmodule

// File: tb/tb_debouncer_multi.sv
// Scoreboard bench for debouncer_multi: stimulus queues expected edge events,
// monitors pop and compare whenever anyChange is raised.
module tb_debouncer_multi;

   typedef struct {
      int         cyc;
      logic [1:0] rise;
      logic [1:0] fall;
      logic [1:0] out;
   } ev_t;

   logic       clk = 1'b0;
   logic       resetN;
   logic       tickEn;
   logic       tick_b;
   logic [1:0] in_a, in_b;
   logic [1:0] out_a, rise_a, fall_a, out_b, rise_b, fall_b;
   logic       any_a, any_b;

   int  cyc = 0;
   int  total = 0;
   int  bad = 0;
   ev_t qa[$];
   ev_t qb[$];
   ev_t ea, eb;
   int  peak;

   debouncer_multi #(.CHANNELS(2), .STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)) dut_a (
      .clk(clk), .resetN(resetN), .tickEn(tickEn), .in(in_a),
      .out(out_a), .rise(rise_a), .fall(fall_a), .anyChange(any_a));

   debouncer_multi #(.CHANNELS(2), .STABLE_CYCLES(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)) dut_b (
      .clk(clk), .resetN(resetN), .tickEn(tick_b), .in(in_b),
      .out(out_b), .rise(rise_b), .fall(fall_b), .anyChange(any_b));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // dly counts edges from the current negedge; edge cyc+1 is the first to sample.
   task automatic push(input bit sel, input int dly, input logic [1:0] r, input logic [1:0] f,
                       input logic [1:0] o);
      ev_t e;
      e.cyc = cyc + dly; e.rise = r; e.fall = f; e.out = o;
      if (sel) qb.push_back(e);
      else qa.push_back(e);
   endtask

   // Monitor: every raised anyChange must match the oldest queued event.
   always @(posedge clk) begin
      #1;
      if (resetN) begin
         chk("a_any_or", {31'd0, any_a}, {31'd0, |{rise_a, fall_a}});
         chk("b_any_or", {31'd0, any_b}, {31'd0, |{rise_b, fall_b}});
         if (any_a) begin
            if (qa.size() == 0) begin
               chk("a_unexpected_pulse", {28'd0, rise_a, fall_a}, 32'd0);
            end else begin
               ea = qa.pop_front();
               chk("a_cycle", cyc, ea.cyc);
               chk("a_rise", {30'd0, rise_a}, {30'd0, ea.rise});
               chk("a_fall", {30'd0, fall_a}, {30'd0, ea.fall});
               chk("a_out", {30'd0, out_a}, {30'd0, ea.out});
            end
         end
         if (any_b) begin
            if (qb.size() == 0) begin
               chk("b_unexpected_pulse", {28'd0, rise_b, fall_b}, 32'd0);
            end else begin
               eb = qb.pop_front();
               chk("b_cycle", cyc, eb.cyc);
               chk("b_rise", {30'd0, rise_b}, {30'd0, eb.rise});
               chk("b_fall", {30'd0, fall_b}, {30'd0, eb.fall});
               chk("b_out", {30'd0, out_b}, {30'd0, eb.out});
            end
         end
      end
   end

   initial begin
      resetN = 1'b1;
      tickEn = 1'b1;
      tick_b = 1'b1;
      in_a   = 2'b11;
      in_b   = 2'b11;
      #1 resetN = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_a", {30'd0, out_a}, 32'd3);
      chk("rst_pulses_a", {27'd0, rise_a, fall_a, any_a}, 32'd0);
      chk("rst_cnt_a0", {29'd0, dut_a.cnt_r[0]}, 32'd0);
      chk("rst_out_b", {30'd0, out_b}, 32'd3);
      resetN = 1'b1;
      repeat (4) @(negedge clk);

      // STABLE_CYCLES=1: toggle in_b[0] every 4 cycles, 3-edge latency
      for (int k = 0; k < 4; k++) begin
         in_b[0] = ~in_b[0];
         if (in_b[0]) push(1'b1, 3, 2'b01, 2'b00, 2'b11);
         else         push(1'b1, 3, 2'b00, 2'b01, 2'b10);
         repeat (4) @(negedge clk);
      end
      repeat (2) @(negedge clk);

      // in[0] 1->0 held: out[0] falls on the 6th edge, out[1] stays 1
      in_a[0] = 1'b0;
      push(1'b0, 6, 2'b00, 2'b01, 2'b10);
      repeat (5) @(negedge clk);
      chk("a_out_before_6th", {30'd0, out_a}, 32'd3);
      repeat (4) @(negedge clk);
      chk("a_out1_hold", {31'd0, out_a[1]}, 32'd1);
      in_a[0] = 1'b1;
      push(1'b0, 6, 2'b01, 2'b00, 2'b11);
      repeat (9) @(negedge clk);

      // 3-cycle glitch: counter peaks at 3 and out never moves
      in_a[0] = 1'b0;
      peak = 0;
      repeat (3) @(negedge clk);
      in_a[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (int'(dut_a.cnt_r[0]) > peak) peak = int'(dut_a.cnt_r[0]);
      end
      chk("glitch_peak", peak, 32'd3);
      chk("glitch_cnt_end", {29'd0, dut_a.cnt_r[0]}, 32'd0);
      chk("glitch_out", {30'd0, out_a}, 32'd3);
      @(negedge clk);

      // tickEn every 3rd cycle: counted ticks on edges +3,+6,+9,+12
      in_a[1] = 1'b0;
      tickEn  = 1'b0;
      push(1'b0, 12, 2'b00, 2'b10, 2'b01);
      for (int j = 2; j <= 16; j++) begin
         @(negedge clk);
         if (j == 12) begin
            chk("tick_out_before", {31'd0, out_a[1]}, 32'd1);
            chk("tick_cnt_before", {29'd0, dut_a.cnt_r[1]}, 32'd3);
         end
         tickEn = (j % 3 == 0);
      end
      @(negedge clk);
      tickEn  = 1'b1;
      in_a[1] = 1'b1;
      push(1'b0, 6, 2'b10, 2'b00, 2'b11);
      repeat (9) @(negedge clk);

      // both channels together
      in_a = 2'b00;
      push(1'b0, 6, 2'b00, 2'b11, 2'b00);
      repeat (9) @(negedge clk);
      in_a = 2'b11;
      push(1'b0, 6, 2'b11, 2'b00, 2'b11);
      repeat (9) @(negedge clk);

      // reset mid-count discards progress; no pulse at release
      in_a[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_cnt", {29'd0, dut_a.cnt_r[0]}, 32'd2);
      resetN = 1'b0;
      #1;
      chk("mid_rst_out", {30'd0, out_a}, 32'd3);
      chk("mid_rst_cnt", {29'd0, dut_a.cnt_r[0]}, 32'd0);
      chk("mid_rst_pulses", {27'd0, rise_a, fall_a, any_a}, 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      push(1'b0, 6, 2'b00, 2'b01, 2'b10);
      repeat (9) @(negedge clk);
      in_a[0] = 1'b1;
      push(1'b0, 6, 2'b01, 2'b00, 2'b11);
      repeat (12) @(negedge clk);

      chk("qa_drained", qa.size(), 32'd0);
      chk("qb_drained", qb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/debouncer_multi.md
DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent input channels; legal range 1..32.
REQ-002 Parameter STABLE_CYCLES, default 1000: counted ticks of continuous mismatch required to accept a new level; legal minimum 1.
REQ-003 Parameter SYNC_STAGES, default 2: flip-flop synchroniser depth per channel; legal minimum 2.
REQ-004 Parameter RESET_LEVEL, default 1: level loaded into every synchroniser stage and every out bit at reset; suits the high idle level of PS/2 lines.
REQ-005 clk  input  1  single clock for all state.
REQ-006 resetN  input  1  asynchronous, active-low reset.
REQ-007 tickEn  input  1  count-enable prescale strobe; tie high to count every clk.
REQ-008 in  input  CHANNELS  raw, asynchronous channel inputs.
REQ-009 out  output  CHANNELS  debounced levels, registered.
REQ-010 rise  output  CHANNELS  one-cycle pulse when the matching out bit goes 0->1.
REQ-011 fall  output  CHANNELS  one-cycle pulse when the matching out bit goes 1->0.
REQ-012 anyChange  output  1  OR of all rise and fall bits, same cycle.

Function
REQ-013 Each channel shall pass in[i] through a SYNC_STAGES-deep synchroniser; the last stage is s[i].
REQ-014 Each channel shall own a counter cnt[i] of width clog2(STABLE_CYCLES+1); channels shall share no state.
REQ-015 On each clk edge with s[i]==out[i], cnt[i] shall clear to 0, whatever tickEn is.
REQ-016 With s[i]!=out[i] and tickEn=0, cnt[i] and out[i] shall hold.
REQ-017 With s[i]!=out[i], tickEn=1 and cnt[i]<STABLE_CYCLES-1, cnt[i] shall increment by 1.
REQ-018 With s[i]!=out[i], tickEn=1 and cnt[i]==STABLE_CYCLES-1, out[i] shall load s[i] and cnt[i] shall clear on the same edge.
REQ-019 rise[i]/fall[i] shall be registered and shall be high for exactly the one cycle in which out[i] first shows its new value.
REQ-020 cnt[i] shall never exceed STABLE_CYCLES-1 and shall never wrap.
REQ-021 Latency with tickEn held high: an in[i] change held stable shall appear on out[i] exactly SYNC_STAGES+STABLE_CYCLES clk edges after the first edge that samples it.
REQ-022 A mismatch of fewer than STABLE_CYCLES consecutive counted ticks shall not change out[i]; any return to match restarts the count from 0.
REQ-023 Channels changing simultaneously shall each produce their own pulses in the same cycle; anyChange shall be a single-cycle high.
REQ-024 With STABLE_CYCLES=1, out[i] shall follow s[i] one tickEn-qualified edge later.

Reset
REQ-025 While resetN=0: all synchroniser stages and out shall equal RESET_LEVEL, cnt shall be 0, and rise, fall and anyChange shall be 0, asynchronously.
REQ-026 Asserting resetN mid-count shall discard the count; after release, counting shall restart from 0 against the RESET_LEVEL out value.
REQ-027 Reset release shall not of itself produce any rise, fall or anyChange pulse.

Verification
REQ-028 Use CHANNELS=2, STABLE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=1, tickEn=1. Drive in[0] 1->0 and hold -> out[0]=0 on the 6th edge; fall[0]=1 and anyChange=1 for that one cycle only; out[1] stays 1.
REQ-029 Same setup. Pulse in[0] low for 3 cycles, then high -> out[0] stays 1; no fall/rise pulses; cnt[0] peaks at 3 and then returns to 0.
REQ-030 Same setup with tickEn high only every 3rd cycle. Drive in[1] 1->0 and hold -> out[1] changes only after 4 counted ticks, on the edge of the 4th counted tick.
REQ-031 Same setup. Drive both in bits 1->0 on the same edge -> fall=2'b11 for one cycle and anyChange high for one cycle; then drive both 0->1 -> rise=2'b11.
REQ-032 Same setup. Hold in[0] low, pulse resetN low for 1 cycle at cnt[0]=2 -> out[0]=1 and cnt[0]=0 immediately; out[0]=0 follows 6 edges after release; no pulse at release.
REQ-033 STABLE_CYCLES=1. Toggle in[0] every 4 cycles -> out[0] tracks with 3-edge latency; each transition gives exactly one rise or fall pulse.
